// File: rtl/gate_bist_ctrl.sv
// Built-in self test sequencer for a 2-input gate: drives 00,01,10,11, waits SETTLE_CYCLES, checks y_in.
// Latency 4*(SETTLE_CYCLES+1) cycles from start to done; no backpressure, abort cancels a run.
// Define GATE_BIST_ERRLOG_EN to add first_fail_vec/first_fail_vld capture of the first mismatch.
module gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int GATE_OP       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count
`ifdef GATE_BIST_ERRLOG_EN
    ,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_vld
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] vec;
    logic [3:0] cnt;
    logic [1:0] vec_nxt;
    logic       expected;
    logic       mismatch;
    logic [2:0] fail_nxt;

    always_comb begin
        vec_nxt = vec + 2'd1;
        case (GATE_OP)
            1:       expected = vec[1] | vec[0];
            2:       expected = vec[1] ^ vec[0];
            3:       expected = ~(vec[1] & vec[0]);
            default: expected = vec[1] & vec[0];
        endcase
        mismatch = (y_in != expected);
        // Saturate at 4; only four vectors exist, so this guards against corrupt state only.
        fail_nxt = (mismatch && fail_count < 3'd4) ? fail_count + 3'd1 : fail_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 2'd0;
            cnt        <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 3'd0;
`ifdef GATE_BIST_ERRLOG_EN
            first_fail_vec <= 2'd0;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        vec        <= 2'd0;
                        cnt        <= 4'd0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_count <= 3'd0;
`ifdef GATE_BIST_ERRLOG_EN
                        first_fail_vec <= 2'd0;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == CNT_LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        fail_count <= fail_nxt;
`ifdef GATE_BIST_ERRLOG_EN
                        if (mismatch && !first_fail_vld) begin
                            first_fail_vec <= vec;
                            first_fail_vld <= 1'b1;
                        end
`endif
                        if (vec == 2'd3) begin
                            state <= DONE;
                            a_out <= 1'b0;
                            b_out <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_nxt == 3'd0);
                        end else begin
                            state <= SETTLE;
                            vec   <= vec_nxt;
                            cnt   <= 4'd0;
                            a_out <= vec_nxt[1];
                            b_out <= vec_nxt[0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: AND instance (SETTLE_CYCLES=2) with fault injection, plus an XOR instance (SETTLE_CYCLES=1).
module tb_gate_bist_ctrl;
    localparam int S0 = 2;
    localparam int S1 = 1;
    localparam int RUN0 = 4 * (S0 + 1);

    logic       clk = 1'b0;
    logic       rst_n, start, abort, y_in, a_out, b_out, busy, done, pass;
    logic [2:0] fail_count;
    logic       start1, y1, a1, b1, busy1, done1, pass1;
    logic [2:0] fail_count1;
`ifdef GATE_BIST_ERRLOG_EN
    logic [1:0] ffv, ffv1;
    logic       ffvld, ffvld1;
`endif

    logic [3:0] mask;
    logic       force_one;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] m;
        logic       f1;
        logic [2:0] exp_fail;
        logic       exp_pass;
    } vec_t;

    always #5 clk = ~clk;

    // Gate under test: a correct AND, with per-vector inversion faults or y stuck at 1.
    assign y_in = force_one ? 1'b1 : ((a_out & b_out) ^ mask[{a_out, b_out}]);
    assign y1   = a1 ^ b1;

    gate_bist_ctrl #(.SETTLE_CYCLES(S0), .GATE_OP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count)
`ifdef GATE_BIST_ERRLOG_EN
        , .first_fail_vec(ffv), .first_fail_vld(ffvld)
`endif
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(S1), .GATE_OP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fail_count1)
`ifdef GATE_BIST_ERRLOG_EN
        , .first_fail_vec(ffv1), .first_fail_vld(ffvld1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bad_vec(input logic [3:0] m, input logic f1, input int v);
        if (f1) return (v != 3);
        return m[v];
    endfunction

    // Mismatches recorded when the run is cut short before cycle k (cycle 0 = first SETTLE cycle).
    function automatic int model_fails(input logic [3:0] m, input logic f1, input int k);
        int n = 0;
        for (int v = 0; v < 4; v++)
            if (v * (S0 + 1) + S0 < k && bad_vec(m, f1, v)) n++;
        return n;
    endfunction

    task automatic run0(input logic [3:0] m, input logic f1, input int abort_at,
                        input logic [2:0] exp_fail, input logic exp_pass, input string tag);
        int j = 0;
        int seq_err = 0;
        int ev;
        bit aborted = 0;
        mask = m;
        force_one = f1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && j < 64) begin
            ev = j / (S0 + 1);
            if (!busy || {a_out, b_out} != ev[1:0]) seq_err++;
            if (j == abort_at) abort = 1'b1;
            tick();
            j++;
            if (abort) begin
                abort = 1'b0;
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            chk({tag, " abort busy"}, busy, 0);
            chk({tag, " abort done"}, done, 0);
            chk({tag, " abort ab"}, {a_out, b_out}, 0);
            chk({tag, " abort fail_count"}, fail_count, exp_fail);
        end else begin
            chk({tag, " latency"}, j, RUN0);
            chk({tag, " done"}, done, 1);
            chk({tag, " busy"}, busy, 0);
            chk({tag, " pass"}, pass, exp_pass);
            chk({tag, " fail_count"}, fail_count, exp_fail);
            chk({tag, " ab sequence errors"}, seq_err, 0);
`ifdef GATE_BIST_ERRLOG_EN
            begin
                int fv = 0;
                for (int v = 3; v >= 0; v--) if (bad_vec(m, f1, v)) fv = v;
                chk({tag, " first_fail_vld"}, ffvld, exp_fail != 0);
                if (exp_fail != 0) chk({tag, " first_fail_vec"}, ffv, fv);
            end
`endif
        end
    endtask

    task automatic wait_ab(input logic [1:0] want, input string tag);
        int k = 0;
        while (!({a_out, b_out} == want && busy) && k < 64) begin
            tick();
            k++;
        end
        chk({tag, " wait vector"}, k < 64, 1);
    endtask

    initial begin
        vec_t tbl[6];
        int k;
        tbl[0] = '{4'b0000, 1'b0, 3'd0, 1'b1};
        tbl[1] = '{4'b0001, 1'b0, 3'd1, 1'b0};
        tbl[2] = '{4'b1000, 1'b0, 3'd1, 1'b0};
        tbl[3] = '{4'b0110, 1'b0, 3'd2, 1'b0};
        tbl[4] = '{4'b1111, 1'b0, 3'd4, 1'b0};
        tbl[5] = '{4'b0000, 1'b1, 3'd3, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;
        mask = 4'b0; force_one = 1'b0;
        #12;
        chk("reset outputs", {a_out, b_out, busy, done, pass, fail_count}, 0);
        chk("reset outputs dut1", {a1, b1, busy1, done1, pass1, fail_count1}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        chk("idle without start", {busy, done}, 0);

        foreach (tbl[i]) run0(tbl[i].m, tbl[i].f1, -1, tbl[i].exp_fail, tbl[i].exp_pass, $sformatf("tbl%0d", i));

        // DONE holds its results; abort there is ignored.
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        chk("done hold", done, 1);
        chk("done hold fail_count", fail_count, 3);

        // Abort during the SETTLE of vector 10.
        mask = 4'b0001; force_one = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_ab(2'b10, "abort10");
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort10 state", {busy, done, a_out, b_out}, 0);
        chk("abort10 fail_count held", fail_count, 1);
        run0(4'b0000, 1'b0, -1, 3'd0, 1'b1, "after abort");

        // Asynchronous reset during CHECK of vector 01.
        mask = 4'b0001;
        start = 1'b1; tick(); start = 1'b0;
        wait_ab(2'b01, "rst01");
        for (int i = 0; i < S0; i++) tick();
        chk("rst01 pre fail_count", fail_count, 1);
        rst_n = 1'b0;
        #1;
        chk("rst01 async outputs", {a_out, b_out, busy, done, pass, fail_count}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        chk("rst01 idle after release", busy, 0);
        run0(4'b0000, 1'b0, -1, 3'd0, 1'b1, "after reset");

        // start held high: no restart while busy, restart right after DONE.
        mask = 4'b0000;
        start = 1'b1; tick();
        k = 0;
        while (!done && k < 64) begin tick(); k++; end
        chk("held start latency", k, RUN0);
        chk("held start pass", pass, 1);
        tick();
        chk("held start restart", {busy, done, a_out, b_out}, 4'b1000);
        start = 1'b0;
        k = 0;
        while (!done && k < 64) begin tick(); k++; end
        chk("held start second run", {done, pass}, 2'b11);

        // XOR instance, SETTLE_CYCLES=1.
        start1 = 1'b1; tick(); start1 = 1'b0;
        k = 0;
        while (!done1 && k < 64) begin tick(); k++; end
        chk("xor latency", k, 4 * (S1 + 1));
        chk("xor result", {done1, pass1, fail_count1}, 5'b11000);

        // Random runs, some aborted, against the vector-count model.
        for (int r = 0; r < 24; r++) begin
            logic [3:0] m;
            int ab;
            int ef;
            m = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RUN0 - 1)) : -1;
            ef = model_fails(m, 1'b0, (ab < 0) ? RUN0 : ab);
            run0(m, 1'b0, ab, 3'(ef), ef == 0, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
